// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
//   state_e   : control FSM states (IDLE, RUN, PAUSE)
//   sw_time_t : packed BCD time {min, sec, hund}, 24 bits
//   to_bcd2   : binary (0..99) to two-digit BCD, used for limit constants
package stopwatch_pkg;

  localparam int unsigned HUND_MAX = 99;
  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned BCD2_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  typedef struct packed {
    logic [BCD2_W-1:0] min;
    logic [BCD2_W-1:0] sec;
    logic [BCD2_W-1:0] hund;
  } sw_time_t;

  // Two-digit BCD encoding of a small binary constant.
  function automatic logic [BCD2_W-1:0] to_bcd2(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after MODULO (binary value).
// Ports:
//   clk, rstn  : clock, async active-low reset
//   inc_i      : advance by one
//   clr_i      : synchronous clear (highest priority)
//   hold_i     : freeze the value even when inc_i is set
//   val_o      : current value, tens digit in [7:4]
//   carry_c_o  : combinational, inc_i while the value sits at MODULO
module bcd_mod_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MODULO = 99
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              inc_i,
  input  logic              clr_i,
  input  logic              hold_i,
  output logic [BCD2_W-1:0] val_o,
  output logic              carry_c_o
);

  localparam logic [BCD2_W-1:0] LAST_BCD = to_bcd2(MODULO);

  logic [BCD2_W-1:0] val_q, val_d;
  logic              at_last_c;

  assign at_last_c = (val_q == LAST_BCD);

  // Carry ignores hold so the top level can detect the saturating advance
  // without a combinational loop through hold_i.
  assign carry_c_o = inc_i && at_last_c;

  // Next value: clear, wrap, or BCD increment with tens carry.
  always_comb begin
    val_d = val_q;
    if (clr_i) begin
      val_d = '0;
    end else if (inc_i && !hold_i) begin
      if (at_last_c) begin
        val_d = '0;
      end else if (val_q[3:0] == 4'd9) begin
        val_d = {val_q[7:4] + 4'd1, 4'd0};
      end else begin
        val_d = {val_q[7:4], val_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping core: counts qualified tick_en strobes into BCD
// mm:ss.hh under a start/stop/clear/lap control FSM, saturating at
// MAX_MIN:59.99.
// Ports:
//   clk, rstn    : clock, async active-low reset
//   tick_en      : count strobe from speed control
//   start_stop   : toggles run/pause (pulse)
//   clear        : zeroes everything (pulse, highest priority)
//   lap          : toggles the lap snapshot display (pulse)
//   running      : state is RUN
//   lap_active   : display shows the lap snapshot
//   overflow     : sticky saturation flag
//   hund_bcd, sec_bcd, min_bcd : displayed time, BCD
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_HUND = 1,
  parameter int unsigned MAX_MIN        = 59
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tick_en,
  input  logic              start_stop,
  input  logic              clear,
  input  logic              lap,
  output logic              running,
  output logic              lap_active,
  output logic              overflow,
  output logic [BCD2_W-1:0] hund_bcd,
  output logic [BCD2_W-1:0] sec_bcd,
  output logic [BCD2_W-1:0] min_bcd
);

  localparam int unsigned       PRE_W    = 8;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICKS_PER_HUND - 1);

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  sw_time_t         snap_q, snap_d;
  logic             lap_q, lap_d;
  logic             ovf_q, ovf_d;

  sw_time_t         live_c;
  sw_time_t         disp_c;
  logic             counted_c;
  logic             hund_inc_c;
  logic             sec_inc_c;
  logic             min_inc_c;
  logic             sat_c;

  // A strobe counts only in RUN; clear wins over everything.
  assign counted_c  = tick_en && (state_q == ST_RUN) && !clear;
  assign hund_inc_c = counted_c && (pre_q == PRE_LAST);

  // Digit chain; the minutes carry marks an advance past MAX_MIN:59.99,
  // which freezes all three digits instead of wrapping.
  bcd_mod_counter #(.MODULO(HUND_MAX)) u_hund (
    .clk       (clk),
    .rstn      (rstn),
    .inc_i     (hund_inc_c),
    .clr_i     (clear),
    .hold_i    (sat_c),
    .val_o     (live_c.hund),
    .carry_c_o (sec_inc_c)
  );

  bcd_mod_counter #(.MODULO(SEC_MAX)) u_sec (
    .clk       (clk),
    .rstn      (rstn),
    .inc_i     (sec_inc_c),
    .clr_i     (clear),
    .hold_i    (sat_c),
    .val_o     (live_c.sec),
    .carry_c_o (min_inc_c)
  );

  bcd_mod_counter #(.MODULO(MAX_MIN)) u_min (
    .clk       (clk),
    .rstn      (rstn),
    .inc_i     (min_inc_c),
    .clr_i     (clear),
    .hold_i    (sat_c),
    .val_o     (live_c.min),
    .carry_c_o (sat_c)
  );

  // Control FSM, lap snapshot, prescaler and overflow next-state.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    snap_d  = snap_q;
    lap_d   = lap_q;
    ovf_d   = ovf_q;

    if (clear) begin
      state_d = ST_IDLE;
      pre_d   = '0;
      snap_d  = '0;
      lap_d   = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      // Lap is judged against the pre-transition state.
      if (lap) begin
        if ((state_q == ST_RUN) && !lap_q) begin
          snap_d = live_c;
          lap_d  = 1'b1;
        end else if ((state_q != ST_IDLE) && lap_q) begin
          lap_d  = 1'b0;
        end
      end

      if (start_stop) begin
        case (state_q)
          ST_IDLE:  state_d = ST_RUN;
          ST_RUN:   state_d = ST_PAUSE;
          ST_PAUSE: state_d = ovf_q ? ST_PAUSE : ST_RUN;
          default:  state_d = ST_IDLE;
        endcase
      end else if ((state_q != ST_IDLE) && (state_q != ST_RUN) &&
                   (state_q != ST_PAUSE)) begin
        state_d = ST_IDLE;
      end

      if (counted_c) begin
        pre_d = hund_inc_c ? '0 : pre_q + PRE_W'(1);
      end

      if (sat_c) begin
        ovf_d   = 1'b1;
        state_d = ST_PAUSE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      snap_q  <= '0;
      lap_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      snap_q  <= snap_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
    end
  end

  // Display select: frozen snapshot while a lap is shown.
  assign disp_c     = lap_q ? snap_q : live_c;
  assign hund_bcd   = disp_c.hund;
  assign sec_bcd    = disp_c.sec;
  assign min_bcd    = disp_c.min;
  assign running    = (state_q == ST_RUN);
  assign lap_active = lap_q;
  assign overflow   = ovf_q;

endmodule
